// File: rtl/sdm_chan_tx.sv
// Synchronous-to-QDI transmitter for one SDM virtual circuit: a small flit FIFO feeding
// a four-phase 1-of-4 encoder with a separate eof token, handshaking on a synchronized ack.
module sdm_chan_tx #(
    parameter int DW   = 8,
    parameter int SCN  = DW / 2,
    parameter int FD   = 4,
    parameter int SYNC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  din,
    input  logic           din_last,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [SCN-1:0] o0,
    output logic [SCN-1:0] o1,
    output logic [SCN-1:0] o2,
    output logic [SCN-1:0] o3,
    output logic           o4,
    input  logic           oa,
    output logic           busy
);

    localparam int AW = $clog2(FD);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DATA = 3'd1;
    localparam logic [2:0] DRTZ = 3'd2;
    localparam logic [2:0] EOF  = 3'd3;
    localparam logic [2:0] ERTZ = 3'd4;

    logic [SYNC-1:0]         sync_q;
    logic                    oas;

    logic [DW:0]             mem_q [FD];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    ready_q, ready_d;
    logic                    empty, push, pop;
    logic [DW:0]             head;

    logic [2:0]              state_q, state_d;
    logic [3:0][SCN-1:0]     rails_q, rails_d;
    logic [3:0][SCN-1:0]     enc;
    logic                    eof_q, eof_d;
    logic                    last_q, last_d;

    // The ack is fully asynchronous; only the last synchronizer stage may steer the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], oa};
        end
    end

    assign oas = sync_q[SYNC-1];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = din_valid & ready_q;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    // Ready is computed from the next pointers so the registered flag is exact every cycle.
    assign ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {din_last, din};
        end
    end

    always_comb begin
        enc = '0;
        for (int j = 0; j < SCN; j++) begin
            enc[head[2*j +: 2]][j] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rails_d = rails_q;
        eof_d   = eof_q;
        last_d  = last_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !oas) begin
                    rails_d = enc;
                    last_d  = head[DW];
                    pop     = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (oas) begin
                    rails_d = '0;
                    state_d = DRTZ;
                end
            end
            DRTZ: begin
                if (!oas) begin
                    if (last_q) begin
                        eof_d   = 1'b1;
                        state_d = EOF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EOF: begin
                if (oas) begin
                    eof_d   = 1'b0;
                    state_d = ERTZ;
                end
            end
            ERTZ: begin
                if (!oas) begin
                    state_d = IDLE;
                end
            end
            default: begin
                rails_d = '0;
                eof_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Rails are flops so the QDI outputs are glitch-free; reset forces the spacer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rails_q <= '0;
            eof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rails_q <= rails_d;
            eof_q   <= eof_d;
            last_q  <= last_d;
        end
    end

    assign o0        = rails_q[0];
    assign o1        = rails_q[1];
    assign o2        = rails_q[2];
    assign o3        = rails_q[3];
    assign o4        = eof_q;
    assign din_ready = ready_q;
    assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_sdm_chan_tx.sv
// Scoreboard bench for sdm_chan_tx: stimulus queues expected tokens, a router-side
// ack process acts as the receiver and checks every token, its timing and its stability.
module tb_sdm_chan_tx;

    localparam int DW   = 8;
    localparam int SCN  = DW / 2;
    localparam int FD   = 4;
    localparam int SYNC = 2;
    localparam int TW   = 4 * SCN + 1;

    logic           clk;
    logic           rst_n;
    logic [DW-1:0]  din;
    logic           din_last;
    logic           din_valid;
    logic           din_ready;
    logic [SCN-1:0] o0, o1, o2, o3;
    logic           o4;
    logic           oa;
    logic           busy;

    logic           ackLevel;
    logic           forceOa;
    logic           holdAck;

    int             compareCount = 0;
    int             failCount    = 0;

    logic [TW-1:0]  expQ[$];
    logic [TW-1:0]  rails;

    assign rails = {o4, o3, o2, o1, o0};
    assign oa    = ackLevel | forceOa;

    sdm_chan_tx #(.DW(DW), .SCN(SCN), .FD(FD), .SYNC(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_last  (din_last),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o4        (o4),
        .oa        (oa),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding: each 2-bit digit v of the flit raises bit j of rail v.
    function automatic logic [TW-1:0] dataToken(input logic [DW-1:0] d);
        logic [TW-1:0] t;
        int v;
        t = '0;
        for (int j = 0; j < SCN; j++) begin
            v = (int'(d) >> (2 * j)) % 4;
            t[v * SCN + j] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [TW-1:0] eofToken();
        logic [TW-1:0] t;
        t = '0;
        t[4 * SCN] = 1'b1;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offers one flit, waiting (bounded) for din_ready, and records the tokens it must produce.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            checkOutput("pushReady", {31'd0, din_ready}, 32'd1);
            return;
        end
        din       = d;
        din_last  = l;
        din_valid = 1'b1;
        @(posedge clk);
        expQ.push_back(dataToken(d));
        if (l) expQ.push_back(eofToken());
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy || ackLevel) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, n >= 3000}, 32'd0);
    endtask

    // Router model: checks each token against the scoreboard, then completes the handshake.
    initial begin : ackProc
        logic [TW-1:0] tok;
        int cycles;
        int dly;
        bit holdBad;
        bit spacerBad;
        ackLevel = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && rails != '0) begin
                tok = rails;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedToken", 32'(tok), 32'd0);
                end else begin
                    checkOutput("token", 32'(tok), 32'(expQ.pop_front()));
                end
                while (holdAck) @(negedge clk);
                holdBad = 1'b0;
                dly = $urandom_range(1, 3);
                repeat (dly) begin
                    @(negedge clk);
                    if (rails != tok) holdBad = 1'b1;
                end
                ackLevel = 1'b1;
                cycles = 0;
                do begin
                    @(negedge clk);
                    cycles++;
                    if (rails != '0 && rails != tok) holdBad = 1'b1;
                end while (rails != '0 && cycles < 64);
                checkOutput("rtzDelay", 32'(cycles), 32'(SYNC + 1));
                checkOutput("railHold", {31'd0, holdBad}, 32'd0);
                spacerBad = 1'b0;
                dly = $urandom_range(1, 3);
                repeat (dly) begin
                    @(negedge clk);
                    if (rails != '0) spacerBad = 1'b1;
                end
                ackLevel = 1'b0;
                checkOutput("spacerHold", {31'd0, spacerBad}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        bit quiet;
        rst_n     = 1'b1;
        din       = '0;
        din_last  = 1'b0;
        din_valid = 1'b0;
        forceOa   = 1'b0;
        holdAck   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("resetRails", 32'(rails), 32'd0);
        checkOutput("resetReady", {31'd0, din_ready}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("readyAfterReset", {31'd0, din_ready}, 32'd1);

        $display("[TB] single flit 0xB4");
        applyStimulus(8'hB4, 1'b0);
        drain("drainSingle");

        $display("[TB] frame tail");
        applyStimulus(8'h00, 1'b1);
        drain("drainFrame");
        checkOutput("frameBusy", {31'd0, busy}, 32'd0);

        $display("[TB] fifo full");
        holdAck = 1'b1;
        for (int i = 0; i < FD + 1; i++) begin
            applyStimulus(DW'($urandom), 1'b0);
        end
        checkOutput("fullReady", {31'd0, din_ready}, 32'd0);
        checkOutput("fullBusy", {31'd0, busy}, 32'd1);
        holdAck = 1'b0;
        n = 0;
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyReturn", {31'd0, din_ready}, 32'd1);
        drain("drainFull");

        $display("[TB] spurious ack");
        forceOa = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(8'h5A, 1'b1);
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rails != '0) quiet = 1'b0;
        end
        checkOutput("spuriousHold", {31'd0, quiet}, 32'd1);
        forceOa = 1'b0;
        drain("drainSpurious");

        $display("[TB] randomized back-to-back traffic");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(DW'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("drainRandom");

        $display("[TB] reset mid-token");
        holdAck = 1'b1;
        applyStimulus(8'hC3, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        n = 0;
        while (rails == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midTokenShown", {31'd0, rails != '0}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRailsClear", 32'(rails), 32'd0);
        checkOutput("resetMidReady", {31'd0, din_ready}, 32'd0);
        checkOutput("resetMidBusy", {31'd0, busy}, 32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("postResetReady", {31'd0, din_ready}, 32'd1);
        checkOutput("postResetRails", 32'(rails), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
